// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the sequenced reset-release controller.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      HOLD,
      WAIT_RDY,
      GAP,
      DONE,
      ERR
   } state_t;

   // A single counter serves the hold, gap and timeout intervals, so it is sized for the largest one.
   function automatic int cnt_width(input int hold_c, input int gap_c, input int tmo_c);
      int m;
      m = hold_c;
      if (gap_c > m) m = gap_c;
      if (tmo_c > m) m = tmo_c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module rst_seq_cnt #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic [W-1:0] o_count,
   output logic         o_zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_load)
         cnt_d = i_load_val;
      else if (i_en && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   // NOTE: no reset here; the parent asserts i_load while its reset is high.
   always_ff @(posedge i_clk) begin
      cnt_q <= cnt_d;
   end

   assign o_count = cnt_q;
   assign o_zero  = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Sequenced reset-release controller: releases domains in index order, waiting for each ready.
// Optional ready timeout enabled by defining RST_SEQ_TIMEOUT_EN.
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int NUM_DOMAINS    = 4,
   parameter int HOLD_CYCLES    = 8,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_req_reset,
   input  logic [NUM_DOMAINS-1:0] i_dom_rdy,
   output logic [NUM_DOMAINS-1:0] o_dom_rst,
   output logic                   o_done,
   output logic                   o_err,
   output logic [IW-1:0]          o_dom_idx
);

   localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
`ifdef RST_SEQ_TIMEOUT_EN
   localparam logic [CW-1:0] TMO_LD  = CW'(TIMEOUT_CYCLES - 1);
   logic                   err_q;
`endif

   state_t                 state_q;
   logic [IW-1:0]          idx_q;
   logic [NUM_DOMAINS-1:0] dom_rst_q;
   logic                   done_q;

   logic          cnt_load, cnt_en, cnt_zero;
   logic [CW-1:0] cnt_ld_val, cnt_q;
   logic          rdy_cur, last_dom;
   logic [IW-1:0] idx_nxt;

   assign rdy_cur  = i_dom_rdy[idx_q];
   assign last_dom = (idx_q == IW'(NUM_DOMAINS - 1));
   assign idx_nxt  = idx_q + IW'(1);

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      cnt_load   = 1'b0;
      cnt_ld_val = HOLD_LD;
      cnt_en     = 1'b0;
      if (i_rst) begin
         cnt_load = 1'b1;
      end else begin
         case (state_q)
            HOLD: begin
               cnt_en = 1'b1;
`ifdef RST_SEQ_TIMEOUT_EN
               if (cnt_zero) begin
                  cnt_load   = 1'b1;
                  cnt_ld_val = TMO_LD;
               end
`endif
            end
            WAIT_RDY: begin
               if (rdy_cur && !last_dom) begin
                  cnt_load   = 1'b1;
                  cnt_ld_val = GAP_LD;
               end
`ifdef RST_SEQ_TIMEOUT_EN
               else if (!rdy_cur) begin
                  cnt_en = 1'b1;
               end
`endif
            end
            GAP: begin
               cnt_en = 1'b1;
`ifdef RST_SEQ_TIMEOUT_EN
               if (cnt_zero) begin
                  cnt_load   = 1'b1;
                  cnt_ld_val = TMO_LD;
               end
`endif
            end
            DONE, ERR: cnt_load = i_req_reset;
            default: ;
         endcase
      end
   end

   rst_seq_cnt #(.W(CW)) u_cnt (
      .i_clk      (i_clk),
      .i_load     (cnt_load),
      .i_load_val (cnt_ld_val),
      .i_en       (cnt_en),
      .o_count    (cnt_q),
      .o_zero     (cnt_zero)
   );

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= HOLD;
         idx_q     <= '0;
         dom_rst_q <= '1;
         done_q    <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
         err_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            HOLD: begin
               if (cnt_zero) begin
                  state_q      <= WAIT_RDY;
                  idx_q        <= '0;
                  dom_rst_q[0] <= 1'b0;
               end
            end
            WAIT_RDY: begin
               if (rdy_cur) begin
                  if (last_dom) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= GAP;
                  end
               end
`ifdef RST_SEQ_TIMEOUT_EN
               else if (cnt_zero) begin
                  state_q   <= ERR;
                  err_q     <= 1'b1;
                  dom_rst_q <= '1;
                  done_q    <= 1'b0;
               end
`endif
            end
            GAP: begin
               if (cnt_zero) begin
                  state_q            <= WAIT_RDY;
                  idx_q              <= idx_nxt;
                  dom_rst_q[idx_nxt] <= 1'b0;
               end
            end
            DONE, ERR: begin
               if (i_req_reset) begin
                  state_q   <= HOLD;
                  idx_q     <= '0;
                  dom_rst_q <= '1;
                  done_q    <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
                  err_q     <= 1'b0;
`endif
               end
            end
            default: state_q <= HOLD;
         endcase
      end
   end

   // The hold interval always starts from a fresh load, never from a leftover count.
   always_ff @(posedge i_clk) begin
      if (!i_rst && state_q == HOLD)
         assert (cnt_q <= HOLD_LD);
   end

   assign o_dom_rst = dom_rst_q;
   assign o_done    = done_q;
   assign o_dom_idx = idx_q;
`ifdef RST_SEQ_TIMEOUT_EN
   assign o_err     = err_q;
`else
   assign o_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: scripted stimulus queues expected output changes with their edge numbers.
module tb_rst_seq_ctrl;

   localparam int ND = 3;

   typedef struct {
      int          edge_n;
      logic [2:0]  rst;
      logic        done;
      logic        err;
      logic [1:0]  idx;
   } ev_t;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_req_reset;
   logic [ND-1:0] i_dom_rdy;
   logic [ND-1:0] o_dom_rst;
   logic          o_done;
   logic          o_err;
   logic [1:0]    o_dom_idx;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   end_req = 1'b0;
   bit   end_done = 1'b0;
   ev_t  exp_q[$];

   rst_seq_ctrl #(
      .NUM_DOMAINS    (ND),
      .HOLD_CYCLES    (4),
      .GAP_CYCLES     (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req_reset (i_req_reset),
      .i_dom_rdy   (i_dom_rdy),
      .o_dom_rst   (o_dom_rst),
      .o_done      (o_done),
      .o_err       (o_err),
      .o_dom_idx   (o_dom_idx)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Monitor: every change of the output tuple must match the next queued expectation.
   logic [6:0] cur, prev;
   ev_t        ev;
   always @(negedge i_clk) begin
      cur = {o_dom_rst, o_done, o_err, o_dom_idx};
      if (cur !== prev) begin
         prev = cur;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: edge %0d rst %b done %b err %b idx %0d, required no change",
                     cyc, o_dom_rst, o_done, o_err, o_dom_idx);
         end else begin
            ev = exp_q.pop_front();
            if (ev.edge_n != cyc || o_dom_rst !== ev.rst || o_done !== ev.done ||
                o_err !== ev.err || o_dom_idx !== ev.idx) begin
               errors++;
               $display("FAIL output_change: got edge %0d rst %b done %b err %b idx %0d, required edge %0d rst %b done %b err %b idx %0d",
                        cyc, o_dom_rst, o_done, o_err, o_dom_idx,
                        ev.edge_n, ev.rst, ev.done, ev.err, ev.idx);
            end
         end
      end
      if (end_req && !end_done) begin
         end_done = 1'b1;
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_changes: got %0d still pending (next at edge %0d), required 0",
                     exp_q.size(), exp_q[0].edge_n);
         end
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_until(input int e);
      while (cyc < e) step();
   endtask

   task automatic expect_ev(input int e, input logic [2:0] r, input logic d,
                            input logic er, input logic [1:0] ix);
      ev_t v;
      v.edge_n = e;
      v.rst    = r;
      v.done   = d;
      v.err    = er;
      v.idx    = ix;
      exp_q.push_back(v);
   endtask

   // One-cycle re-run request from DONE/ERR; returns the edge that restarted the hold.
   task automatic do_req(output int t0);
      expect_ev(cyc + 1, 3'b111, 1'b0, 1'b0, 2'd0);
      i_req_reset = 1'b1;
      step();
      i_req_reset = 1'b0;
      t0 = cyc;
   endtask

   // Full sequence from a fresh hold loaded at edge t0; dk = edges from release k to the edge sampling rdy[k].
   task automatic run_seq(input int t0, input int d0, input int d1, input int d2, input bit gap_req);
      int d[3];
      int rel[3];
      int samp[3];
      d[0] = d0; d[1] = d1; d[2] = d2;
      rel[0] = t0 + 4;
      for (int k = 0; k < 3; k++) begin
         samp[k] = rel[k] + d[k];
         if (k < 2) rel[k+1] = samp[k] + 2;
      end
      expect_ev(rel[0],  3'b110, 1'b0, 1'b0, 2'd0);
      expect_ev(rel[1],  3'b100, 1'b0, 1'b0, 2'd1);
      expect_ev(rel[2],  3'b000, 1'b0, 1'b0, 2'd2);
      expect_ev(samp[2], 3'b000, 1'b1, 1'b0, 2'd2);
      for (int k = 0; k < 3; k++) begin
         wait_until(samp[k] - 1);
         i_dom_rdy[k] = 1'b1;
         if (k == 0 && gap_req) begin
            wait_until(samp[0]);
            i_req_reset = 1'b1;
            step();
            i_req_reset = 1'b0;
         end
      end
      wait_until(samp[2]);
   endtask

   int t0, rel0, rel1;

   initial begin
      i_rst       = 1'b1;
      i_req_reset = 1'b0;
      i_dom_rdy   = '0;

      // Reset for three edges, then the basic staggered sequence.
      expect_ev(1, 3'b111, 1'b0, 1'b0, 2'd0);
      wait_until(3);
      i_rst = 1'b0;
      run_seq(3, 3, 3, 3, 1'b0);

      // Readies dropping while DONE are ignored.
      i_dom_rdy = '0;
      repeat (4) step();

      // Re-run with every ready already high: the gaps still apply.
      i_dom_rdy = '1;
      do_req(t0);
      run_seq(t0, 1, 1, 1, 1'b0);

      // Re-run with a request pulsed during GAP, which must be ignored.
      i_dom_rdy = '0;
      do_req(t0);
      run_seq(t0, 3, 3, 3, 1'b1);

      // Reset asserted while waiting on domain 1, then a full restart.
      i_dom_rdy = '0;
      do_req(t0);
      rel0 = t0 + 4;
      rel1 = rel0 + 3;
      expect_ev(rel0, 3'b110, 1'b0, 1'b0, 2'd0);
      expect_ev(rel1, 3'b100, 1'b0, 1'b0, 2'd1);
      wait_until(rel0);
      i_dom_rdy[0] = 1'b1;
      wait_until(rel1 + 1);
      expect_ev(rel1 + 2, 3'b111, 1'b0, 1'b0, 2'd0);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      i_dom_rdy = '0;
      run_seq(cyc, 2, 2, 2, 1'b0);

`ifdef RST_SEQ_TIMEOUT_EN
      // Ready rising on the expiry edge wins over the timeout.
      i_dom_rdy = '0;
      do_req(t0);
      run_seq(t0, 16, 1, 1, 1'b0);

      // Domain 1 never ready: error after 16 edges, held until a request.
      i_dom_rdy = '0;
      do_req(t0);
      rel0 = t0 + 4;
      rel1 = rel0 + 3;
      expect_ev(rel0, 3'b110, 1'b0, 1'b0, 2'd0);
      expect_ev(rel1, 3'b100, 1'b0, 1'b0, 2'd1);
      expect_ev(rel1 + 16, 3'b111, 1'b0, 1'b1, 2'd1);
      wait_until(rel0);
      i_dom_rdy[0] = 1'b1;
      wait_until(rel1 + 24);
      i_dom_rdy = '0;
      do_req(t0);
      run_seq(t0, 2, 2, 2, 1'b0);
`else
      // Without the timeout a very late ready still completes normally.
      i_dom_rdy = '0;
      do_req(t0);
      run_seq(t0, 1000, 2, 2, 1'b0);
`endif

      repeat (4) step();
      end_req = 1'b1;
      repeat (3) step();
      if (!end_done) begin
         $display("FAIL end_check: got monitor idle, required final queue check");
         $fatal(1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
